broad_share_tx: RTL and testbench
=================================

# broad_share_tx

Streams the TAU·D_HYPERCUBE broadcast shares into the `hash_2` broadcast-share port, one 32·T·3-bit share per valid/ready transfer. It is the transmitter for `hash_2`'s `i_broad_share_valid` / `o_broad_share_ready` / `i_broad_share` receiver. Shares are fetched 32 bits at a time from a single-port share BRAM with one-cycle read latency. Each share is packed into a wide word before it is presented.

## Interface
Parameters:
- `PARAMETER_SET`, "L5": selects TAU ("L1" → 17, "L3" → 26, "L5" → 34, otherwise 17).
- `T`, 3: number of field-element triples per share.
- `TAU`, derived from `PARAMETER_SET`: number of repetitions.
- `D_HYPERCUBE`, 8: shares per repetition.
- `SHARE_WORDS`, 3·T: 32-bit words per share (9 by default).
- `SHARE_SIZE`, 32·SHARE_WORDS: width of one share in bits (288 by default).
- `NUM_SHARES`, TAU·D_HYPERCUBE: total shares streamed per run (272 for L5).
- `MEM_DEPTH`, NUM_SHARES·SHARE_WORDS: depth of the share BRAM in words.

Ports:
- `i_clk`  in  1: clock, rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_start`  in  1: one-cycle start pulse; honoured only in IDLE.
- `o_done`  out  1: one-cycle pulse after the last share is accepted.
- `o_busy`  out  1: high in every state except IDLE.
- `o_mem_addr`  out  `CLOG2(MEM_DEPTH)`: share BRAM word address.
- `o_mem_rd`  out  1: BRAM read enable.
- `i_mem_data`  in  32: BRAM read data; valid one cycle after `o_mem_rd`.
- `o_broad_share`  out  SHARE_SIZE: packed share; connects to `hash_2.i_broad_share`.
- `o_broad_share_valid`  out  1: connects to `hash_2.i_broad_share_valid`.
- `i_broad_share_ready`  in  1: connects to `hash_2.o_broad_share_ready`.
- `o_share_index`  out  `CLOG2(NUM_SHARES)`: index of the share currently held or being fetched.

## Operation
- States:
  - IDLE
  - FETCH
  - DRAIN
  - PRESENT
  - DONE
- IDLE:
  - Counters `share_idx` and `word_idx` are held at 0.
  - `i_start` → FETCH.
- FETCH:
  - `o_mem_rd` = 1 and `o_mem_addr` = share_idx·SHARE_WORDS + word_idx.
  - `word_idx` increments each cycle.
  - After `word_idx` = SHARE_WORDS−1 is issued, go to DRAIN.
- Capture: the data returned for word k is written to `o_broad_share[SHARE_SIZE−1−32k -: 32]`. Word 0 is most significant. Capture happens the cycle after each read, so it also occurs in the first FETCH cycle of the next share and in DRAIN.
- DRAIN:
  - `o_mem_rd` = 0.
  - The last word is captured.
  - Go to PRESENT.
- PRESENT:
  - `o_broad_share_valid` = 1; `o_broad_share` and `o_share_index` are stable.
  - Transfer occurs when valid & ready in the same cycle.
  - On transfer:
    - If `share_idx` = NUM_SHARES−1 → DONE.
    - Otherwise `share_idx`++, `word_idx` = 0, go to FETCH.
  - Ready low: hold indefinitely with no reads issued.
  - Ready asserted before valid: legal; the transfer occurs in the first PRESENT cycle.
- DONE: `o_done` = 1 for one cycle → IDLE.
- Address arithmetic: the base address is a running register incremented by SHARE_WORDS per share. No multiplier is used. The maximum address is MEM_DEPTH−1 and never wraps.
- `i_start` in any non-IDLE state is ignored.
- Reset in any state:
  - Return to IDLE.
  - Counters and the share register are cleared.
  - No transfer occurs in the reset cycle.

## Timing
- Reset values:
  - `o_done` = 0, `o_busy` = 0, `o_mem_rd` = 0.
  - `o_mem_addr` = 0, `o_broad_share` = 0.
  - `o_broad_share_valid` = 0, `o_share_index` = 0.
- `i_start` sampled at cycle 0:
  - FETCH occupies cycles 1..SHARE_WORDS (1..9).
  - DRAIN occupies cycle 10.
  - `o_broad_share_valid` first goes high at cycle 11.
- Per share: SHARE_WORDS+1 fetch cycles, plus at least one PRESENT cycle. With ready held high, shares are spaced 11 cycles apart.
- `o_broad_share_valid` drops the cycle after a transfer. It is never high in two consecutive cycles across a share boundary.
- Transfer of the last share at cycle c:
  - `o_done` = 1 at c+1.
  - `o_busy` = 0 at c+2.
- With ready always high, start-to-done is NUM_SHARES·11+1 cycles (2993 for L5).
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Load BRAM word a = a. Start with ready held high. Expect:
  - Share 0 = {32'd0, 32'd1, …, 32'd8}, with word 0 in the top 32 bits.
  - Valid first at cycle 11.
  - 272 transfers; `o_done` at cycle 2993.
- Hold ready low for 50 cycles while in PRESENT on share 5. Expect:
  - Valid stays high and `o_broad_share` is stable.
  - `o_mem_rd` stays 0 throughout.
  - Share 5 = words 45..53.
- Drive ready like `hash_2` does: ready rises, then is held high 9 cycles later. Expect one transfer per ready episode and no lost or duplicated shares. Check by scoreboard comparison of all 272 shares.
- Pulse `i_start` again during share 3. Expect:
  - No restart; `o_share_index` continues 3 → 4.
  - Exactly one `o_done`.
- Assert `i_rst` in FETCH of share 10, then start again. Expect:
  - All outputs at their reset values the next cycle.
  - The new run begins at address 0 with share index 0.
- Check the last share with PARAMETER_SET "L1". Expect:
  - NUM_SHARES = 136.
  - Final address 1223.
  - `o_done` after exactly 136 transfers.

Source files
------------

// File: rtl/broad_share_tx_if.sv
// Broadcast-share stream from broad_share_tx into the hash_2 receiver port.
// Signal names are those of the transmitter's original ports.
interface broad_share_tx_if #(
  parameter int SHARE_SIZE = 288
);
  logic [SHARE_SIZE-1:0] o_broad_share;
  logic                  o_broad_share_valid;
  logic                  i_broad_share_ready;

  modport master (
    output o_broad_share,
    output o_broad_share_valid,
    input  i_broad_share_ready
  );

  modport slave (
    input  o_broad_share,
    input  o_broad_share_valid,
    output i_broad_share_ready
  );
endinterface

// File: rtl/broad_share_tx.sv
// Fetches TAU*D_HYPERCUBE shares word-by-word from the share BRAM, packs each
// into a wide word (word 0 most significant) and presents it on a valid/ready port.
module broad_share_tx #(
  parameter     PARAMETER_SET = "L5",
  parameter int T             = 3,
  parameter int TAU           = (PARAMETER_SET == "L1") ? 17 :
                                (PARAMETER_SET == "L3") ? 26 :
                                (PARAMETER_SET == "L5") ? 34 : 17,
  parameter int D_HYPERCUBE   = 8,
  parameter int SHARE_WORDS   = 3 * T,
  parameter int SHARE_SIZE    = 32 * SHARE_WORDS,
  parameter int NUM_SHARES    = TAU * D_HYPERCUBE,
  parameter int MEM_DEPTH     = NUM_SHARES * SHARE_WORDS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic                          o_done,
  output logic                          o_busy,
  output logic [$clog2(MEM_DEPTH)-1:0]  o_mem_addr,
  output logic                          o_mem_rd,
  input  logic [31:0]                   i_mem_data,
  broad_share_tx_if.master              o_bs,
  output logic [$clog2(NUM_SHARES)-1:0] o_share_index
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int IDX_W  = $clog2(NUM_SHARES);
  localparam int WORD_W = (SHARE_WORDS > 1) ? $clog2(SHARE_WORDS) : 1;

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(SHARE_WORDS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SHARES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(SHARE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                           r_state, w_state_nx;
  logic [WORD_W-1:0]                r_word, w_word_nx;
  logic [ADDR_W-1:0]                r_addr, w_addr_nx;
  logic [ADDR_W-1:0]                r_base, w_base_nx;
  logic [IDX_W-1:0]                 r_idx, w_idx_nx;
  logic                             r_mem_rd, r_valid, r_done, r_busy;
  logic                             r_cap_en;
  logic [WORD_W-1:0]                r_cap_slot;
  logic [SHARE_WORDS-1:0][31:0]     r_words;
  logic                             w_xfer;

  assign w_xfer = r_valid && o_bs.i_broad_share_ready;

  always_comb begin
    w_state_nx = r_state;
    w_word_nx  = r_word;
    w_addr_nx  = r_addr;
    w_base_nx  = r_base;
    w_idx_nx   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        w_word_nx = '0;
        w_addr_nx = '0;
        w_base_nx = '0;
        w_idx_nx  = '0;
        if (i_start) w_state_nx = S_FETCH;
      end
      S_FETCH: begin
        // The address stops on the last word so it never runs past MEM_DEPTH-1.
        if (r_word == WORD_LAST) begin
          w_state_nx = S_DRAIN;
        end else begin
          w_word_nx = r_word + WORD_W'(1);
          w_addr_nx = r_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: w_state_nx = S_PRESENT;
      S_PRESENT: begin
        if (w_xfer) begin
          if (r_idx == IDX_LAST) begin
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_FETCH;
            w_word_nx  = '0;
            w_idx_nx   = r_idx + IDX_W'(1);
            w_base_nx  = r_base + ADDR_STEP;
            w_addr_nx  = r_base + ADDR_STEP;
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_word_nx  = '0;
        w_addr_nx  = '0;
        w_base_nx  = '0;
        w_idx_nx   = '0;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so none is a decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_word   <= '0;
      r_addr   <= '0;
      r_base   <= '0;
      r_idx    <= '0;
      r_mem_rd <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_word   <= w_word_nx;
      r_addr   <= w_addr_nx;
      r_base   <= w_base_nx;
      r_idx    <= w_idx_nx;
      r_mem_rd <= (w_state_nx == S_FETCH);
      r_valid  <= (w_state_nx == S_PRESENT);
      r_done   <= (w_state_nx == S_DONE);
      r_busy   <= (w_state_nx != S_IDLE);
    end
  end

  // Read data lands one cycle after the read; slot SHARE_WORDS-1 is the top word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cap_en   <= 1'b0;
      r_cap_slot <= '0;
      r_words    <= '0;
    end else begin
      r_cap_en   <= r_mem_rd;
      r_cap_slot <= WORD_LAST - r_word;
      if (r_cap_en) r_words[r_cap_slot] <= i_mem_data;
    end
  end

  assign o_done                   = r_done;
  assign o_busy                   = r_busy;
  assign o_mem_rd                 = r_mem_rd;
  assign o_mem_addr               = r_addr;
  assign o_share_index            = r_idx;
  assign o_bs.o_broad_share       = r_words;
  assign o_bs.o_broad_share_valid = r_valid;

endmodule

// File: tb/tb_broad_share_tx.sv
// Randomized bench for broad_share_tx (L5 and L1 instances) against a share-level
// model built from the BRAM contents: share n = words n*9 .. n*9+8, word 0 on top.
module tb_broad_share_tx;
  localparam int SW     = 9;
  localparam int N5     = 272;
  localparam int N1     = 136;
  localparam int DEPTH5 = N5 * SW;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic        done5, busy5, rd5, valid5;
  logic [11:0] addr5;
  logic [8:0]  idx5;
  logic [31:0] rdata5;
  logic        done1, busy1, rd1, valid1;
  logic [10:0] addr1;
  logic [7:0]  idx1;
  logic [31:0] rdata1;
  logic [31:0] mem [DEPTH5];

  int n_checks = 0;
  int n_fail   = 0;

  broad_share_tx_if #(.SHARE_SIZE(288)) bs5 ();
  broad_share_tx_if #(.SHARE_SIZE(288)) bs1 ();
  assign bs5.i_broad_share_ready = ready;
  assign bs1.i_broad_share_ready = 1'b1;
  assign valid5 = bs5.o_broad_share_valid;
  assign valid1 = bs1.o_broad_share_valid;

  broad_share_tx #(.PARAMETER_SET("L5")) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_done(done5), .o_busy(busy5),
    .o_mem_addr(addr5), .o_mem_rd(rd5), .i_mem_data(rdata5), .o_bs(bs5),
    .o_share_index(idx5)
  );

  broad_share_tx #(.PARAMETER_SET("L1")) dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_done(done1), .o_busy(busy1),
    .o_mem_addr(addr1), .o_mem_rd(rd1), .i_mem_data(rdata1), .o_bs(bs1),
    .o_share_index(idx1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd5) rdata5 <= mem[addr5];
    if (rd1) rdata1 <= mem[addr1];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_share(input string name, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [287:0] exp_share(input int n);
    logic [287:0] s;
    for (int k = 0; k < SW; k++) s[287 - 32*k -: 32] = mem[n*SW + k];
    return s;
  endfunction

  // Model / compare state
  int cyc = 0, start_cyc = 0;
  int first_valid_rel = -1, done_rel = -1, done1_rel = -1;
  int done_cnt = 0, done1_cnt = 0;
  int exp5 = 0, rdc5 = 0, xf5 = 0;
  int exp1 = 0, rdc1 = 0, max1 = 0;
  bit want_first = 0, pxf5 = 0, last5 = 0, bpend5 = 0, last1 = 0, rst_pend = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rst_pend = 1; want_first = 0;
      exp5 = 0; rdc5 = 0; xf5 = 0; pxf5 = 0; last5 = 0; bpend5 = 0;
      exp1 = 0; rdc1 = 0; max1 = 0; last1 = 0;
    end else begin
      if (rst_pend) begin
        rst_pend = 0;
        check("rst_done", done5, 0);
        check("rst_busy", busy5, 0);
        check("rst_rd", rd5, 0);
        check("rst_addr", addr5, 0);
        check("rst_valid", valid5, 0);
        check("rst_index", idx5, 0);
        check_share("rst_share", bs5.o_broad_share, '0);
        check("rst_l1_busy", busy1, 0);
        check("rst_l1_valid", valid1, 0);
      end
      if (start && !busy5) begin
        start_cyc  = cyc;
        want_first = 1;
      end

      // L5 instance
      if (rd5) begin
        check("rd_addr", addr5, exp5*SW + rdc5);
        check("rd_index", idx5, exp5);
        check("rd_count", rdc5 < SW, 1);
        rdc5++;
      end
      if (pxf5) check("valid_drop", valid5, 0);
      if (last5 || done5) check("done_timing", done5, last5);
      if (bpend5) check("busy_after_done", busy5, 0);
      bpend5 = done5;
      if (done5) begin
        check("transfers", xf5, N5);
        done_cnt++;
        done_rel = cyc - start_cyc;
        exp5 = 0; xf5 = 0; rdc5 = 0;
      end
      last5 = 0;
      pxf5  = 0;
      if (valid5) begin
        if (want_first) begin
          first_valid_rel = cyc - start_cyc;
          want_first = 0;
        end
        check("valid_index", idx5, exp5);
        check_share("share", bs5.o_broad_share, exp_share(exp5));
        check("no_rd_in_present", rd5, 0);
        check("words_fetched", rdc5, SW);
        if (ready) begin
          pxf5  = 1;
          last5 = (exp5 == N5 - 1);
          exp5++; xf5++; rdc5 = 0;
        end
      end

      // L1 instance, ready tied high
      if (rd1) begin
        check("l1_rd_addr", addr1, exp1*SW + rdc1);
        rdc1++;
        if (int'(addr1) > max1) max1 = int'(addr1);
      end
      if (last1 || done1) check("l1_done_timing", done1, last1);
      if (done1) begin
        check("l1_transfers", exp1, N1);
        check("l1_max_addr", max1, 1223);
        done1_cnt++;
        done1_rel = cyc - start_cyc;
        exp1 = 0; rdc1 = 0; max1 = 0;
      end
      last1 = 0;
      if (valid1) begin
        check("l1_index", idx1, exp1);
        check_share("l1_share", bs1.o_broad_share, exp_share(exp1));
        last1 = (exp1 == N1 - 1);
        exp1++; rdc1 = 0;
      end
    end
  end

  initial begin
    logic [287:0] lit0, lit5;
    int  dc;
    bit  held, rd_any, v_all;

    rst = 1; start = 0; ready = 0;
    for (int a = 0; a < DEPTH5; a++) mem[a] = a;
    repeat (3) tick();
    rst = 0;
    tick();

    lit0 = {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    lit5 = {32'd45, 32'd46, 32'd47, 32'd48, 32'd49, 32'd50, 32'd51, 32'd52, 32'd53};
    check_share("model_share0", exp_share(0), lit0);
    check_share("model_share5", exp_share(5), lit5);

    // Run A: identity memory, ready high, second start pulse during share 3
    ready = 1;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 20 && !valid5; i++) tick();
    check_share("first_share", bs5.o_broad_share, lit0);
    for (int i = 0; i < 100 && idx5 != 3; i++) tick();
    check("reach_share3", idx5, 3);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 30 && idx5 == 3; i++) tick();
    check("after_share3", idx5, 4);
    for (int i = 0; i < 4000 && busy5; i++) tick();
    check("runA_idle", busy5, 0);
    check("first_valid_cycle", first_valid_rel, 11);
    check("done_cycle", done_rel, 2993);
    check("done_count", done_cnt, 1);
    check("l1_done_cycle", done1_rel, 1497);
    check("l1_done_count", done1_cnt, 1);

    // Run B: random data, random ready, ready held low 50 cycles on share 5
    for (int a = 0; a < DEPTH5; a++) mem[a] = $urandom;
    dc = done_cnt; held = 0; ready = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 20000 && busy5; i++) begin
      if (!held && valid5 && idx5 == 5) begin
        ready = 0; rd_any = 0; v_all = 1;
        repeat (50) begin
          tick();
          rd_any |= rd5;
          v_all  &= valid5;
        end
        held = 1;
        check("hold_valid", v_all, 1);
        check("hold_no_read", rd_any, 0);
        check("hold_index", idx5, 5);
      end
      ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    ready = 0;
    check("runB_idle", busy5, 0);
    check("runB_held", held, 1);
    check("runB_done_count", done_cnt, dc + 1);

    // Run C: receiver-style ready episodes
    for (int i = 0; i < 3000 && busy1; i++) tick();
    for (int a = 0; a < DEPTH5; a++) mem[a] = $urandom;
    dc = done_cnt;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 4000 && busy5; i++) begin
      ready = 0; repeat ($urandom_range(1, 12)) tick();
      ready = 1; repeat ($urandom_range(1, 3)) tick();
    end
    ready = 0;
    check("runC_idle", busy5, 0);
    check("runC_done_count", done_cnt, dc + 1);

    // Run D: reset during FETCH of share 10, then a fresh run
    for (int i = 0; i < 3000 && busy1; i++) tick();
    for (int a = 0; a < DEPTH5; a++) mem[a] = $urandom;
    ready = 1;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 300 && !(idx5 == 10 && rd5); i++) tick();
    check("reach_fetch10", (idx5 == 10 && rd5), 1);
    rst = 1; tick(); rst = 0;
    check("rst_now_busy", busy5, 0);
    check("rst_now_rd", rd5, 0);
    check_share("rst_now_share", bs5.o_broad_share, '0);
    tick(); tick();
    start = 1; tick(); start = 0;
    check("restart_rd", rd5, 1);
    check("restart_addr", addr5, 0);
    check("restart_index", idx5, 0);
    for (int i = 0; i < 4000 && busy5; i++) tick();
    check("runD_idle", busy5, 0);
    for (int i = 0; i < 3000 && busy1; i++) tick();
    check("l1_idle", busy1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
